// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: code constants,
// default period table and counter widths.
package pwm_pkg;

    localparam int DUTY_W = 9;
    localparam int CNT_W  = 10;

    localparam logic [1:0] FS_00 = 2'b00;
    localparam logic [1:0] FS_01 = 2'b01;
    localparam logic [1:0] FS_10 = 2'b10;
    localparam logic [1:0] FS_11 = 2'b11;

    localparam int unsigned DEF_PER0    = 500;
    localparam int unsigned DEF_PER1    = 400;
    localparam int unsigned DEF_PER2    = 250;
    localparam int unsigned DEF_PER3    = 100;
    localparam int unsigned DEF_TOL     = 2;
    localparam int unsigned DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_STUCK = 2'd2
    } cap_state_t;

    // True when value lies within centre +/- tol; written to avoid unsigned underflow.
    function automatic logic in_window(input logic [31:0] value,
                                       input int unsigned centre,
                                       input int unsigned tol);
        return ((value + tol) >= centre) && (value <= (centre + tol));
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a third flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module pwm_edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign sync = sync_reg;
    assign rise = sync_reg & ~prev_reg;
    assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform rise-to-rise: reports high time, period
// and the matching period-table code once per complete period.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned PER0    = DEF_PER0,
    parameter int unsigned PER1    = DEF_PER1,
    parameter int unsigned PER2    = DEF_PER2,
    parameter int unsigned PER3    = DEF_PER3,
    parameter int unsigned TOL     = DEF_TOL,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pwm_in,
    output logic              meas_valid,
    output logic [DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]  period_out,
    output logic [1:0]        freq_sel_out,
    output logic              freq_error,
    output logic              stuck,
    output logic              stuck_level
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam int unsigned PER_TAB [0:3] = '{PER0, PER1, PER2, PER3};

    logic sync;
    logic rise;
    logic fall;

    pwm_edge_sync u_edge_sync (
        .clk    (clk),
        .resetn (resetn),
        .raw    (pwm_in),
        .sync   (sync),
        .rise   (rise),
        .fall   (fall)
    );

    cap_state_t        state_reg;
    logic [CNT_W-1:0]  period_cnt_reg;
    logic [DUTY_W-1:0] high_cnt_reg;
    logic [DUTY_W-1:0] duty_hold_reg;
    logic              meas_valid_reg;
    logic [DUTY_W-1:0] duty_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [1:0]        freq_sel_reg;
    logic              freq_error_reg;
    logic              stuck_reg;
    logic              stuck_level_reg;

    logic [3:0] hit;
    logic [1:0] match_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_match
            assign hit[gi] = in_window(32'(period_cnt_reg), PER_TAB[gi], TOL);
        end
    endgenerate

    // Lowest-index entry wins when tolerance windows overlap.
    always_comb begin
        match_sel = FS_00;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                match_sel = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            period_cnt_reg  <= '0;
            high_cnt_reg    <= '0;
            duty_hold_reg   <= '0;
            meas_valid_reg  <= 1'b0;
            duty_reg        <= '0;
            period_reg      <= '0;
            freq_sel_reg    <= FS_00;
            freq_error_reg  <= 1'b0;
            stuck_reg       <= 1'b0;
            stuck_level_reg <= 1'b0;
        end else begin
            meas_valid_reg <= 1'b0;
            freq_error_reg <= 1'b0;
            if (rise) begin
                // The rise cycle itself is the first counted cycle of the new period.
                period_cnt_reg <= CNT_W'(1);
                high_cnt_reg   <= DUTY_W'(1);
                stuck_reg      <= 1'b0;
                state_reg      <= ST_ARMED;
                if (state_reg == ST_ARMED) begin
                    meas_valid_reg <= 1'b1;
                    duty_reg       <= duty_hold_reg;
                    period_reg     <= period_cnt_reg;
                    if (|hit) begin
                        freq_sel_reg <= match_sel;
                    end else begin
                        freq_error_reg <= 1'b1;
                    end
                end
            end else begin
                if (period_cnt_reg != CNT_MAX) begin
                    period_cnt_reg <= period_cnt_reg + CNT_W'(1);
                end
                if (sync && (high_cnt_reg != DUTY_MAX)) begin
                    high_cnt_reg <= high_cnt_reg + DUTY_W'(1);
                end
                if (fall) begin
                    duty_hold_reg <= high_cnt_reg;
                end
                if ((state_reg != ST_STUCK) && (period_cnt_reg == TIMEOUT_CNT)) begin
                    state_reg       <= ST_STUCK;
                    stuck_reg       <= 1'b1;
                    stuck_level_reg <= sync;
                end
            end
        end
    end

    assign meas_valid   = meas_valid_reg;
    assign duty_out     = duty_reg;
    assign period_out   = period_reg;
    assign freq_sel_out = freq_sel_reg;
    assign freq_error   = freq_error_reg;
    assign stuck        = stuck_reg;
    assign stuck_level  = stuck_level_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: waveform segments feed a rise-to-rise
// reference model; a monitor checks each reported measurement.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       pwm_in = 1'b0;
    logic       meas_valid;
    logic [8:0] duty_out;
    logic [9:0] period_out;
    logic [1:0] freq_sel_out;
    logic       freq_error;
    logic       stuck;
    logic       stuck_level;

    pwm_capture dut (
        .clk          (clk),
        .resetn       (resetn),
        .pwm_in       (pwm_in),
        .meas_valid   (meas_valid),
        .duty_out     (duty_out),
        .period_out   (period_out),
        .freq_sel_out (freq_sel_out),
        .freq_error   (freq_error),
        .stuck        (stuck),
        .stuck_level  (stuck_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int period;
        int sel;
        int err;
    } meas_t;

    meas_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    per_tab [0:3] = '{500, 400, 250, 100};

    // Reference model state: time since last rise, high time since last rise.
    bit cur_level = 1'b0;
    bit armed     = 1'b0;
    int gap       = 0;
    int high      = 0;
    int last_sel  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_rise();
        meas_t m;
        if (armed && gap <= 1023) begin
            m.period = gap;
            m.duty   = (high > 511) ? 511 : high;
            m.sel    = last_sel;
            m.err    = 1;
            for (int n = 0; n < 4; n++) begin
                if (m.err == 1 && gap >= per_tab[n] - 2 && gap <= per_tab[n] + 2) begin
                    m.sel = n;
                    m.err = 0;
                end
            end
            last_sel = m.sel;
            exp_q.push_back(m);
        end
        armed = 1'b1;
        gap   = 0;
        high  = 0;
    endfunction

    // Hold pwm_in at lvl for n clock periods; the change lands at a random
    // point inside the clock period, as an asynchronous source would.
    task automatic drive_seg(input bit lvl, input int n);
        if (lvl && !cur_level) model_rise();
        cur_level = lvl;
        gap += n;
        if (lvl) high += n;
        @(posedge clk);
        #($urandom_range(1, 8));
        pwm_in = lvl;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic drive_period(input int h, input int p);
        drive_seg(1'b1, h);
        drive_seg(1'b0, p - h);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_duty"}, duty_out, 0);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_freq_sel"}, freq_sel_out, 0);
        check({tag, "_freq_error"}, freq_error, 0);
        check({tag, "_stuck"}, stuck, 0);
        check({tag, "_stuck_level"}, stuck_level, 0);
    endtask

    always @(negedge clk) begin
        meas_t m;
        if (resetn) begin
            if (meas_valid) begin
                $display("[TB] meas duty=%0d period=%0d sel=%0d err=%0b",
                         duty_out, period_out, freq_sel_out, freq_error);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_meas: got duty %0d period %0d, expected no report",
                             duty_out, period_out);
                end else begin
                    m = exp_q.pop_front();
                    check("duty_out", duty_out, m.duty);
                    check("period_out", period_out, m.period);
                    check("freq_sel_out", freq_sel_out, m.sel);
                    check("freq_error", freq_error, m.err);
                end
            end else if (freq_error) begin
                check("freq_error_without_valid", freq_error, 0);
            end
        end
    end

    initial begin
        int p;
        int h;
        int mode;

        #1 resetn = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        // Nominal 500-cycle waveform, then a switch to 100 cycles.
        repeat (4) drive_period(200, 500);
        repeat (3) drive_period(37, 100);

        // In-tolerance period, then an unmatched one.
        repeat (2) drive_period(100, 402);
        drive_period(50, 320);
        drive_period(125, 250);

        // Stuck low, then stuck high.
        drive_seg(1'b0, 1100);
        @(negedge clk);
        check("stuck_low", stuck, 1);
        check("stuck_level_low", stuck_level, 0);
        drive_seg(1'b1, 10);
        @(negedge clk);
        check("stuck_cleared", stuck, 0);
        drive_seg(1'b1, 1090);
        @(negedge clk);
        check("stuck_high", stuck, 1);
        check("stuck_level_high", stuck_level, 1);
        drive_seg(1'b0, 50);

        // Extreme duties, and periods at and just past the timeout.
        repeat (2) drive_period(1, 250);
        repeat (2) drive_period(249, 250);
        drive_period(10, 1023);
        drive_period(10, 1024);
        repeat (2) drive_period(50, 100);

        // Randomized periods: near-table, arbitrary, and duty-saturating.
        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                p = per_tab[$urandom_range(0, 3)] + int'($urandom_range(0, 8)) - 4;
                h = int'($urandom_range(1, p - 1));
            end else if (mode == 1) begin
                p = int'($urandom_range(2, 1023));
                h = int'($urandom_range(1, p - 1));
            end else begin
                p = int'($urandom_range(600, 1023));
                h = int'($urandom_range(512, p - 1));
            end
            drive_period(h, p);
        end

        // Reset asserted in the low phase of a period.
        drive_period(100, 250);
        drive_seg(1'b1, 100);
        drive_seg(1'b0, 60);
        check("queue_empty_before_reset", exp_q.size(), 0);
        #2 resetn = 1'b0;
        #1 check_all_zero("midreset");
        armed     = 1'b0;
        gap       = 0;
        high      = 0;
        last_sel  = 0;
        cur_level = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (3) drive_period(100, 250);

        repeat (20) @(posedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
